// File: rtl/ndata_serializer.sv
// Width-down stream adapter: buffers one multi-lane beat and emits its kept lanes
// one per cycle in ascending lane order, preserving the stream end marker.
module ndata_serializer #(
    parameter type data_t       = logic [7:0],
    parameter int  NUM_ELEMENTS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    // Both ports: a transfer happens on a rising edge where valid && ready; the
    // sender holds its payload stable while valid is high and ready is low.
    input  data_t [NUM_ELEMENTS-1:0]     in_data,
    input  logic  [NUM_ELEMENTS-1:0]     in_keep,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    output data_t                        out_data,
    output logic                         out_keep,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam logic [NUM_ELEMENTS-1:0] ONE = NUM_ELEMENTS'(1);

    data_t [NUM_ELEMENTS-1:0] buf_data;
    logic                     buf_last;
    logic                     buf_valid;
    logic                     term;
    logic [NUM_ELEMENTS-1:0]  rem;

    logic [NUM_ELEMENTS-1:0]  rem_lsb;
    logic [NUM_ELEMENTS-1:0]  rem_rest;
    logic                     final_elem;
    logic                     fire_out;
    logic                     fire_in;

    // Lowest pending lane is isolated as a one-hot mask; clearing it leaves rem_rest.
    assign rem_lsb    = rem & (~rem + ONE);
    assign rem_rest   = rem & ~rem_lsb;
    assign final_elem = term || (rem_rest == '0);

    assign out_valid  = buf_valid;
    assign out_keep   = buf_valid && !term;
    assign out_last   = buf_valid && (term || (buf_last && final_elem));
    assign in_ready   = !rst && (!buf_valid || (out_ready && final_elem));

    assign fire_out   = buf_valid && out_ready;
    assign fire_in    = in_valid && in_ready;

    always_comb begin
        out_data = buf_data[0];
        if (!term) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                if (rem_lsb[i]) begin
                    out_data = buf_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data  <= '0;
            buf_last  <= 1'b0;
            buf_valid <= 1'b0;
            term      <= 1'b0;
            rem       <= '0;
        end else begin
            if (fire_out) begin
                rem <= rem_rest;
                if (final_elem) begin
                    buf_valid <= 1'b0;
                    term      <= 1'b0;
                end
            end
            // A load in the same edge as the final handshake overrides the clear above.
            if (fire_in) begin
                if (in_keep != '0) begin
                    buf_data  <= in_data;
                    buf_last  <= in_last;
                    rem       <= in_keep;
                    buf_valid <= 1'b1;
                    term      <= 1'b0;
                end else if (in_last) begin
                    buf_data  <= in_data;
                    buf_last  <= 1'b1;
                    rem       <= '0;
                    buf_valid <= 1'b1;
                    term      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ndata_serializer.sv
// Directed and backpressure bench for ndata_serializer (4-lane and 1-lane builds);
// a negedge monitor scores every output handshake against an expected queue.
module tb_ndata_serializer;

    logic            clk;
    logic            rst;
    logic [3:0][7:0] in_data;
    logic [3:0]      in_keep;
    logic            in_last;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      out_data;
    logic            out_keep;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;

    logic [7:0]      in1_data;
    logic [0:0]      in1_keep;
    logic            in1_last;
    logic            in1_valid;
    logic            in1_ready;
    logic [7:0]      out1_data;
    logic            out1_keep;
    logic            out1_last;
    logic            out1_valid;
    logic            out1_ready;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    logic       prev_stall;
    logic [9:0] prev_elem;
    logic       bp_done;

    ndata_serializer #(.data_t(logic [7:0]), .NUM_ELEMENTS(4)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    ndata_serializer #(.data_t(logic [7:0]), .NUM_ELEMENTS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_data(in1_data), .in_keep(in1_keep), .in_last(in1_last),
        .in_valid(in1_valid), .in_ready(in1_ready),
        .out_data(out1_data), .out_keep(out1_keep), .out_last(out1_last),
        .out_valid(out1_valid), .out_ready(out1_ready)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] mk(input logic [7:0] d, input logic k, input logic l);
        return {d, k, l};
    endfunction

    // Scoreboard monitor: every handshake must match the head of exp_q; a stalled
    // output must present the same element on the following cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {21'd0, out_valid, out_data, out_keep, out_last},
                      {21'd0, 1'b1, prev_elem});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_out", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("out_elem", {22'd0, out_data, out_keep, out_last},
                          {22'd0, exp_q.pop_front()});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_elem  = {out_data, out_keep, out_last};
        end
    end

    // Driver tasks; callers enter and leave 1 time unit after a rising edge.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("send_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_model(input logic [31:0] d, input logic [3:0] k, input logic l);
        int hi;
        hi = -1;
        for (int i = 0; i < 4; i++) if (k[i]) hi = i;
        if (k == 4'b0000) begin
            if (l) exp_q.push_back(mk(d[7:0], 1'b0, 1'b1));
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (k[i]) exp_q.push_back(mk(d[i*8 +: 8], 1'b1, l && (i == hi)));
            end
        end
    endtask

    initial begin
        int t1_exp[8] = '{10, 11, 12, 13, 20, 21, 22, 23};
        logic [31:0] rd;
        logic [3:0]  rk;
        logic        rl;

        rst = 1'b1;
        in_data = '0; in_keep = '0; in_last = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1;
        in1_data = '0; in1_keep = '0; in1_last = 1'b0; in1_valid = 1'b0;
        out1_ready = 1'b1;
        bp_done = 1'b0;
        prev_stall = 1'b0;
        prev_elem = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_keep_last", {30'd0, out_keep, out_last}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Full beats with continuous ready, back-to-back reload
        for (int i = 0; i < 7; i++) exp_q.push_back(mk(8'(t1_exp[i]), 1'b1, 1'b0));
        exp_q.push_back(mk(8'd23, 1'b1, 1'b1));
        in_data = {8'd13, 8'd12, 8'd11, 8'd10}; in_keep = 4'b1111; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("t1_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_data = {8'd23, 8'd22, 8'd21, 8'd20}; in_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_valid", {31'd0, out_valid}, 32'd1);
            check("t1_data", {24'd0, out_data}, t1_exp[i]);
            check("t1_last", {31'd0, out_last}, {31'd0, 1'(i == 7)});
            check("t1_in_ready", {31'd0, in_ready}, {31'd0, 1'(i == 3 || i == 7)});
            @(posedge clk);
            #1;
            if (i == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        check("t1_empty", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Sparse keep: lanes 1 and 3 only
        exp_q.push_back(mk(8'd1, 1'b1, 1'b0));
        exp_q.push_back(mk(8'd3, 1'b1, 1'b1));
        send_beat({8'd3, 8'd2, 8'd1, 8'd0}, 4'b1010, 1'b1);
        wait_drain();

        // Empty beat without last is swallowed
        in_data = {8'd0, 8'd0, 8'd0, 8'd9}; in_keep = 4'b0000; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("t3_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("t3_no_out", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Terminator beat
        exp_q.push_back(mk(8'd7, 1'b0, 1'b1));
        send_beat({8'd0, 8'd0, 8'd0, 8'd7}, 4'b0000, 1'b1);
        check("t3_term_keep_last", {29'd0, out_valid, out_keep, out_last}, 32'b101);
        wait_drain();

        // Random backpressure over random beats
        fork
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int b = 0; b < 200; b++) begin
                    rd = $urandom;
                    rk = 4'($urandom_range(0, 15));
                    rl = 1'($urandom_range(0, 1));
                    push_model(rd, rk, rl);
                    send_beat(rd, rk, rl);
                end
                bp_done = 1'b1;
            end
        join
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        // Reset after 2 of 4 elements
        exp_q.push_back(mk(8'd30, 1'b1, 1'b0));
        exp_q.push_back(mk(8'd31, 1'b1, 1'b0));
        send_beat({8'd33, 8'd32, 8'd31, 8'd30}, 4'b1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t5_in_ready_rst", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_valid_after", {31'd0, out_valid}, 32'd0);
        check("t5_q_consumed", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(8'd41, 1'b1, 1'b0));
        exp_q.push_back(mk(8'd42, 1'b1, 1'b1));
        send_beat({8'd43, 8'd42, 8'd41, 8'd40}, 4'b0110, 1'b1);
        wait_drain();

        // Single-lane build: pass-through with one cycle latency
        in1_data = 8'd5; in1_keep = 1'b1; in1_last = 1'b0; in1_valid = 1'b1;
        @(negedge clk);
        check("n1_accept", {31'd0, in1_ready}, 32'd1);
        check("n1_idle", {31'd0, out1_valid}, 32'd0);
        @(posedge clk);
        #1 in1_data = 8'd9; in1_last = 1'b1;
        @(negedge clk);
        check("n1_beat0", {21'd0, out1_valid, out1_data, out1_keep, out1_last}, {21'd0, 1'b1, 8'd5, 1'b1, 1'b0});
        check("n1_ready0", {31'd0, in1_ready}, 32'd1);
        @(posedge clk);
        #1 in1_data = 8'd3; in1_keep = 1'b0;
        @(negedge clk);
        check("n1_beat1", {21'd0, out1_valid, out1_data, out1_keep, out1_last}, {21'd0, 1'b1, 8'd9, 1'b1, 1'b1});
        @(posedge clk);
        #1 in1_valid = 1'b0;
        @(negedge clk);
        check("n1_term", {21'd0, out1_valid, out1_data, out1_keep, out1_last}, {21'd0, 1'b1, 8'd3, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        @(negedge clk);
        check("n1_empty", {31'd0, out1_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
